// File: rtl/float_copro_seq.sv
// Operation sequencer for the LM32 floating-point coprocessor: captures a command,
// runs add/sub/mul/div over a per-op latency and returns an IEEE single result.
module float_copro_seq #(
  parameter int unsigned LAT_ADD = 2,
  parameter int unsigned LAT_MUL = 3,
  parameter int unsigned LAT_DIV = 8
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic [2:0]  op_i,
  input  logic [31:0] op_a_i,
  input  logic [31:0] op_b_i,
  input  logic        clr_flags_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [31:0] result_o,
  output logic [2:0]  flags_o
);

  localparam logic [3:0]  CNT_ADD = 4'(LAT_ADD - 1);
  localparam logic [3:0]  CNT_MUL = 4'(LAT_MUL - 1);
  localparam logic [3:0]  CNT_DIV = 4'(LAT_DIV - 1);
  localparam logic [30:0] SAT_MAG = {8'hFE, 23'h7FFFFF};

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

  state_t      state, state_n;
  logic [3:0]  cnt, cnt_n;
  logic [1:0]  op_q, op_n;
  logic [31:0] a_q, a_n, b_q, b_n;
  logic [31:0] res_n, res_c;
  logic [2:0]  flags_n;
  logic        busy_n, done_n, dz_c, sat_c;

  // Internal format: IEEE layout with denormals flushed to zero.
  function automatic logic [31:0] ieee2float(input logic [31:0] x);
    if (x[30:23] == 8'd0) return {x[31], 31'd0};
    return x;
  endfunction

  function automatic logic [31:0] f_add(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] big, sml;
    logic [7:0]  d;
    logic [23:0] mb, ms;
    logic [24:0] sum;
    logic [4:0]  lz;
    logic [8:0]  e;
    if (a[30:23] == 8'd0) return b;
    if (b[30:23] == 8'd0) return a;
    if (a[30:0] >= b[30:0]) begin big = a; sml = b; end
    else begin big = b; sml = a; end
    d  = big[30:23] - sml[30:23];
    mb = {1'b1, big[22:0]};
    ms = (d > 8'd23) ? 24'd0 : ({1'b1, sml[22:0]} >> d);
    e  = {1'b0, big[30:23]};
    if (big[31] == sml[31]) begin
      sum = {1'b0, mb} + {1'b0, ms};
      if (!sum[24]) return {big[31], big[30:23], sum[22:0]};
      if (e >= 9'd254) return {big[31], SAT_MAG};
      return {big[31], 8'(e + 9'd1), sum[23:1]};
    end
    sum = {1'b0, mb - ms};
    if (sum == 25'd0) return 32'd0;
    lz = 5'd0;
    for (int i = 0; i < 24; i++) if (sum[i]) lz = 5'(23 - i);
    if (e <= {4'd0, lz}) return {big[31], 31'd0};
    sum = sum << lz;
    return {big[31], 8'(e - {4'd0, lz}), sum[22:0]};
  endfunction

  function automatic logic [31:0] f_mul(input logic [31:0] a, input logic [31:0] b);
    logic               s;
    logic [24:0]        p;
    logic [22:0]        m;
    logic signed [10:0] e;
    s = a[31] ^ b[31];
    if (a[30:23] == 8'd0 || b[30:23] == 8'd0) return {s, 31'd0};
    p = 25'(({24'd0, 1'b1, a[22:0]} * {24'd0, 1'b1, b[22:0]}) >> 23);
    e = $signed({3'd0, a[30:23]}) + $signed({3'd0, b[30:23]}) - 11'sd127;
    if (p[24]) begin m = p[23:1]; e = e + 11'sd1; end
    else m = p[22:0];
    if (e >= 11'sd255) return {s, SAT_MAG};
    if (e <= 11'sd0) return {s, 31'd0};
    return {s, e[7:0], m};
  endfunction

  function automatic logic [31:0] f_div(input logic [31:0] a, input logic [31:0] b);
    logic               s;
    logic [24:0]        q;
    logic [22:0]        m;
    logic signed [10:0] e;
    s = a[31] ^ b[31];
    if (b[30:23] == 8'd0) return {s, 8'hFF, 23'd0};
    if (a[30:23] == 8'd0) return {s, 31'd0};
    q = 25'({1'b1, a[22:0], 24'd0} / {24'd0, 1'b1, b[22:0]});
    e = $signed({3'd0, a[30:23]}) - $signed({3'd0, b[30:23]}) + 11'sd127;
    if (q[24]) m = q[23:1];
    else begin m = q[22:0]; e = e - 11'sd1; end
    if (e >= 11'sd255) return {s, SAT_MAG};
    if (e <= 11'sd0) return {s, 31'd0};
    return {s, e[7:0], m};
  endfunction

  // Arithmetic on the captured operands, used only in the last EXEC cycle.
  always_comb begin
    case (op_q)
      2'd0:    res_c = f_add(a_q, b_q);
      2'd1:    res_c = f_add(a_q, {~b_q[31], b_q[30:0]});
      2'd2:    res_c = f_mul(a_q, b_q);
      default: res_c = f_div(a_q, b_q);
    endcase
    dz_c  = (op_q == 2'd3) && (b_q[30:23] == 8'd0);
    sat_c = (op_q != 2'd1) && (res_c[30:0] == SAT_MAG) &&
            (a_q[30:0] != SAT_MAG) && (b_q[30:0] != SAT_MAG);
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    op_n    = op_q;
    a_n     = a_q;
    b_n     = b_q;
    res_n   = result_o;
    flags_n = clr_flags_i ? 3'b000 : flags_o;
    case (state)
      IDLE: begin
        if (start_i) begin
          if (op_i[2]) begin
            res_n      = 32'd0;
            flags_n[1] = 1'b1;
            state_n    = DONE;
          end else begin
            op_n    = op_i[1:0];
            a_n     = ieee2float(op_a_i);
            b_n     = ieee2float(op_b_i);
            cnt_n   = (op_i[1:0] == 2'd3) ? CNT_DIV :
                      (op_i[1:0] == 2'd2) ? CNT_MUL : CNT_ADD;
            state_n = EXEC;
          end
        end
      end
      EXEC: begin
        if (cnt == 4'd0) begin
          res_n      = ieee2float(res_c);
          flags_n[0] = flags_n[0] | dz_c;
          flags_n[2] = flags_n[2] | sat_c;
          state_n    = DONE;
        end else begin
          cnt_n = cnt - 4'd1;
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
    busy_n = (state_n == EXEC);
    done_n = (state_n == DONE);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state    <= IDLE;
      cnt      <= 4'd0;
      op_q     <= 2'd0;
      a_q      <= 32'd0;
      b_q      <= 32'd0;
      busy_o   <= 1'b0;
      done_o   <= 1'b0;
      result_o <= 32'd0;
      flags_o  <= 3'b000;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      op_q     <= op_n;
      a_q      <= a_n;
      b_q      <= b_n;
      busy_o   <= busy_n;
      done_o   <= done_n;
      result_o <= res_n;
      flags_o  <= flags_n;
    end
  end

endmodule
